// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the iterative shift-add multiplier.
//   state_e    : FSM encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
//   WIDTH      : operand/result width (32)
//   ITER_LAST  : counter value of the last RUN iteration (31)
//   R0_ADDR    : integer register r0 index (writes to it are dropped)
//   calc_ovf   : overflow of a 64-bit product against a 32-bit result
package mul_pkg;

    localparam int WIDTH     = 32;
    localparam int ITER_LAST = 31;
    localparam logic [4:0] R0_ADDR = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A product overflows when its high word is not the extension of the
    // low word: zero-extension for MULTU, sign-extension of bit 31 for MULT.
    function automatic logic calc_ovf(input logic [63:0] prod, input logic is_sgn);
        logic r;
        if (is_sgn) begin
            r = (prod[63:32] != {32{prod[31]}});
        end else begin
            r = (prod[63:32] != 32'd0);
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_negate.sv
// mul_negate: combinational 64-bit two's complement negate with select.
//   in_i  [63:0] : value
//   neg_i        : 1 = output -in_i, 0 = output in_i unchanged
//   out_o [63:0] : result
module mul_negate (
    input  logic [63:0] in_i,
    input  logic        neg_i,
    output logic [63:0] out_o
);

    // Conditional two's complement.
    always_comb begin
        if (neg_i) begin
            out_o = ~in_i + 64'd1;
        end else begin
            out_o = in_i;
        end
    end

endmodule

// File: rtl/mul_unit.sv
// mul_unit: multi-cycle shift-add multiplier for MULT/MULTU feeding the
// register file write port. One operation in flight at a time.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : request, sampled only in IDLE
//   is_signed             : 1 = MULT, 0 = MULTU
//   op_a, op_b [0:31]     : multiplicand / multiplier (bit 0 = MSB)
//   dest_addr [0:4]       : destination register index
//   dest_ftpt             : 1 = destination in FP register bank
//   busy                  : operation in flight (RUN or DONE)
//   done                  : one-cycle result pulse
//   wr_en                 : register file write enable (never for integer r0)
//   wr_addr [0:4]         : latched destination index
//   wr_data [0:31]        : low word of the product
//   wr_ftpt               : latched FP-bank select
//   ovf                   : product does not fit in 32 bits; valid with done
// Optional build macro MUL_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (variable latency, identical results).
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [0:WIDTH-1] op_a,
    input  logic [0:WIDTH-1] op_b,
    input  logic [0:4]       dest_addr,
    input  logic             dest_ftpt,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [0:4]       wr_addr,
    output logic [0:WIDTH-1] wr_data,
    output logic             wr_ftpt,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [63:0]        acc_q, acc_d;
    logic [32:0]        mcand_q, mcand_d;
    logic [31:0]        mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               sgn_mode_q, sgn_mode_d;
    logic [4:0]         dst_addr_q, dst_addr_d;
    logic               dst_ftpt_q, dst_ftpt_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_en_q, wr_en_d;
    logic [4:0]         wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               wr_ftpt_q, wr_ftpt_d;
    logic               ovf_q, ovf_d;

    logic               neg_a_s, neg_b_s;
    logic [63:0]        a_ext_s, b_ext_s;
    logic [63:0]        a_mag_s, b_mag_s;
    logic [63:0]        prod_s;
    logic [63:0]        addend_s;
    logic               last_s;
    logic               unused_s;

    // Operand magnitudes: sign-extend only for MULT, then negate negatives.
    // 0x80000000 becomes +2^31, which is why the multiplicand keeps 33 bits.
    assign neg_a_s = is_signed & op_a[0];
    assign neg_b_s = is_signed & op_b[0];
    assign a_ext_s = {{32{neg_a_s}}, op_a};
    assign b_ext_s = {{32{neg_b_s}}, op_b};

    mul_negate u_neg_a (
        .in_i  (a_ext_s),
        .neg_i (neg_a_s),
        .out_o (a_mag_s)
    );

    mul_negate u_neg_b (
        .in_i  (b_ext_s),
        .neg_i (neg_b_s),
        .out_o (b_mag_s)
    );

    // Final sign fix applied to the accumulated magnitude.
    mul_negate u_neg_res (
        .in_i  (acc_q),
        .neg_i (sign_q),
        .out_o (prod_s)
    );

    assign unused_s = ^{a_mag_s[63:33], b_mag_s[63:32]};

    assign addend_s = {31'd0, mcand_q} << cnt_q;

`ifdef MUL_EARLY_TERM_EN
    assign last_s = (cnt_q == CNT_W'(ITER_LAST)) || (mplier_q[31:1] == 31'd0);
`else
    assign last_s = (cnt_q == CNT_W'(ITER_LAST));
`endif

    // Next-state and output logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        sgn_mode_d = sgn_mode_q;
        dst_addr_d = dst_addr_q;
        dst_ftpt_d = dst_ftpt_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_ftpt_d  = wr_ftpt_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d      = 64'd0;
                    mcand_d    = a_mag_s[32:0];
                    mplier_d   = b_mag_s[31:0];
                    cnt_d      = {CNT_W{1'b0}};
                    sign_d     = is_signed & (op_a[0] ^ op_b[0]);
                    sgn_mode_d = is_signed;
                    dst_addr_d = dest_addr;
                    dst_ftpt_d = dest_ftpt;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend_s;
                end else begin
                    acc_d = acc_q;
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                done_d    = 1'b1;
                // Integer r0 is hardwired; suppress the write but still finish.
                wr_en_d   = ~((~dst_ftpt_q) && (dst_addr_q == R0_ADDR));
                wr_addr_d = dst_addr_q;
                wr_data_d = prod_s[31:0];
                wr_ftpt_d = dst_ftpt_q;
                ovf_d     = calc_ovf(prod_s, sgn_mode_q);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset (aborts any operation).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= 64'd0;
            mcand_q    <= 33'd0;
            mplier_q   <= 32'd0;
            cnt_q      <= {CNT_W{1'b0}};
            sign_q     <= 1'b0;
            sgn_mode_q <= 1'b0;
            dst_addr_q <= 5'd0;
            dst_ftpt_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 32'd0;
            wr_ftpt_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            sgn_mode_q <= sgn_mode_d;
            dst_addr_q <= dst_addr_d;
            dst_ftpt_q <= dst_ftpt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_ftpt_q  <= wr_ftpt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_ftpt = wr_ftpt_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed scoreboard bench for mul_unit. Stimulus pushes the
// hand-computed expected write into a queue; a negedge monitor pops and
// compares on every done pulse.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [0:31] op_a;
    logic [0:31] op_b;
    logic [0:4]  dest_addr;
    logic        dest_ftpt;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [0:4]  wr_addr;
    logic [0:31] wr_data;
    logic        wr_ftpt;
    logic        ovf;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        logic        ftpt;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .dest_addr (dest_addr),
        .dest_ftpt (dest_ftpt),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ftpt   (wr_ftpt),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("wr_en",   {63'd0, wr_en},   {63'd0, e.en});
                chk("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
                chk("wr_data", {32'd0, wr_data}, {32'd0, e.data});
                chk("wr_ftpt", {63'd0, wr_ftpt}, {63'd0, e.ftpt});
                chk("ovf",     {63'd0, ovf},     {63'd0, e.ovf});
            end
        end
    end

    // Issue one operation, optionally pulsing a second (ignored) start at
    // cycle inject_at of the run, and wait (bounded) for its done pulse.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] addr, input logic ftpt,
                          input logic [31:0] e_data, input logic e_en, input logic e_ovf,
                          input int inject_at, output int cycles);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        dest_addr = addr;
        dest_ftpt = ftpt;
        e.data = e_data;
        e.addr = addr;
        e.en   = e_en;
        e.ftpt = ftpt;
        e.ovf  = e_ovf;
        sb_q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        is_signed = ~sgn;
        op_a      = 32'hDEADBEEF;
        op_b      = 32'h0BADF00D;
        dest_addr = ~addr;
        dest_ftpt = ~ftpt;
        cycles    = 1;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        while (done !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cycles == inject_at) begin
                start = 1'b1;
                op_a  = 32'h00000003;
                op_b  = 32'h00000003;
                chk("busy_at_ignored_start", {63'd0, busy}, 64'd1);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", {63'd0, done}, 64'd1);
`ifdef MUL_EARLY_TERM_EN
        chk("latency_bound", {63'd0, (cycles <= 34)}, 64'd1);
`else
        chk("latency", 64'(cycles), 64'd34);
`endif
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("wr_en_drop", {63'd0, wr_en}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        chk("wr_data_hold", {32'd0, wr_data}, {32'd0, e_data});
    endtask

    initial begin
        int cyc;
        int stray;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        dest_addr = 5'd0;
        dest_ftpt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    {63'd0, busy},    64'd0);
        chk("rst_done",    {63'd0, done},    64'd0);
        chk("rst_wr_en",   {63'd0, wr_en},   64'd0);
        chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        chk("rst_wr_ftpt", {63'd0, wr_ftpt}, 64'd0);
        chk("rst_ovf",     {63'd0, ovf},     64'd0);
        rst = 1'b0;

        // sgn, a, b, addr, ftpt, data, en, ovf
        run_op(1'b0, 32'h00000007, 32'h00000006, 5'd5,  1'b0, 32'h0000002A, 1'b1, 1'b0, 0, cyc);
        run_op(1'b1, 32'hFFFFFFFD, 32'h00000004, 5'd6,  1'b0, 32'hFFFFFFF4, 1'b1, 1'b0, 0, cyc);
        run_op(1'b0, 32'hFFFFFFFD, 32'h00000004, 5'd7,  1'b0, 32'hFFFFFFF4, 1'b1, 1'b1, 0, cyc);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd8,  1'b0, 32'h80000000, 1'b1, 1'b1, 0, cyc);
        run_op(1'b0, 32'h00010000, 32'h00010000, 5'd9,  1'b0, 32'h00000000, 1'b1, 1'b1, 0, cyc);
        run_op(1'b1, 32'h80000000, 32'h00000001, 5'd12, 1'b0, 32'h80000000, 1'b1, 1'b0, 0, cyc);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 1'b0, 32'h00000001, 1'b1, 1'b1, 0, cyc);
        // Integer r0 drops the write; FP f0 does not.
        run_op(1'b0, 32'h00000007, 32'h00000006, 5'd0,  1'b0, 32'h0000002A, 1'b0, 1'b0, 0, cyc);
        run_op(1'b0, 32'h00000007, 32'h00000006, 5'd0,  1'b1, 32'h0000002A, 1'b1, 1'b0, 0, cyc);
        // Second start during RUN is ignored: 5 * 0x80000009 = 0x2_8000002D.
        run_op(1'b0, 32'h00000005, 32'h80000009, 5'd10, 1'b0, 32'h8000002D, 1'b1, 1'b1, 10, cyc);

        // Reset at cycle 15 of RUN aborts with no write or done.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        op_a      = 32'h00000003;
        op_b      = 32'hFFFFFFFF;
        dest_addr = 5'd14;
        dest_ftpt = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("busy_before_abort", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",  {63'd0, busy},  64'd0);
        chk("abort_done",  {63'd0, done},  64'd0);
        chk("abort_wr_en", {63'd0, wr_en}, 64'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || wr_en === 1'b1 || busy === 1'b1) stray++;
        end
        chk("abort_quiet", 64'(stray), 64'd0);

        // Fresh operation after the abort: (-1) * (-1) = 1.
        run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 1'b0, 32'h00000001, 1'b1, 1'b0, 0, cyc);

        // Multiplier of one: shortest run when early termination is built in.
        run_op(1'b0, 32'h00001234, 32'h00000001, 5'd3,  1'b0, 32'h00001234, 1'b1, 1'b0, 0, cyc);
`ifdef MUL_EARLY_TERM_EN
        chk("early_term_latency", {63'd0, (cyc <= 3)}, 64'd1);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Multi-cycle iterative shift-add multiplier for DLX MULT/MULTU (integer) and MULT-to-FP-reg forms.
- Sits directly upstream of the register file write port; its result is muxed onto WrData/WrAddr/WrEn/ftpt_write by the writeback select.
- Accepts one operation at a time via start/busy and produces a one-cycle write request plus a done pulse.

Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU.
- op_a  in  [0:31]  multiplicand; bit 0 is MSB, matching the datapath.
- op_b  in  [0:31]  multiplier; bit 0 is MSB.
- dest_addr  in  [0:4]  destination register index.
- dest_ftpt  in  1  1 = destination is the FP register bank.
- busy  out  1  high while an operation is in flight (RUN or DONE).
- done  out  1  one-cycle pulse when the result is valid.
- wr_en  out  1  register file write enable.
- wr_addr  out  [0:4]  latched dest_addr.
- wr_data  out  [0:31]  low 32 bits of the product.
- wr_ftpt  out  1  latched dest_ftpt; drives ftpt_write.
- ovf  out  1  product does not fit in 32 bits under the selected signedness; valid with done.

Behaviour:
- Reset: state=IDLE; busy, done, wr_en, ovf, wr_ftpt = 0; wr_addr = 0; wr_data = 0; internal accumulator and counter = 0.
- Reset mid-operation aborts the operation. No write and no done pulse are issued.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - Latch dest_addr, dest_ftpt and is_signed.
  - Latch |op_a| and |op_b|. Magnitudes apply only when is_signed=1; 0x80000000 has magnitude 2^31 and needs a 33-bit internal magnitude.
  - Record sign = a_msb XOR b_msb.
  - Clear the 64-bit accumulator; counter = 0.
- RUN: each cycle:
  - If the multiplier LSB = 1, add the multiplicand shifted by counter into the accumulator.
  - Shift the multiplier right by one; counter += 1.
  - After the iteration with counter = 31, go to DONE.
- DONE:
  - Apply the sign: accumulator negated if sign=1.
  - Drive wr_data = low 32 bits for one cycle, with done=1 and wr_en=1. Next edge: IDLE.
- Latency: start sampled at edge N gives busy=1 after N, and done/wr_en high in the cycle after edge N+33. The next start can be accepted at edge N+34.
- start while busy is ignored and not queued.
- Operands and dest inputs are don't-care after the accepting edge.
- ovf:
  - Unsigned: high 32 bits != 0.
  - Signed: the 64-bit result is not equal to the sign-extension of bit 31 of its low word.
  - ovf does not suppress the write.
- Integer r0: if dest_ftpt=0 and dest_addr=0, wr_en stays 0. done still pulses.
- Outputs are registered at posedge, so they are stable across the register file's negedge write.
- wr_addr, wr_data and wr_ftpt hold their last values after DONE. wr_en and done return to 0.

Optional Feature:
- MUL_EARLY_TERM_EN defined: in RUN, when the remaining shifted multiplier is all zero, go to DONE on the next edge. This gives variable latency, minimum 2 cycles for op_b=0 (RUN for 1 cycle, then DONE). Results are identical.
- Undefined: fixed 32-cycle RUN as specified above.

Decomposition:
- Package mul_pkg holds:
  - the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the WIDTH=32 and ITER_LAST=31 constants;
  - the r0 index constant.
- One sub-module, mul_negate: combinational 64-bit two's complement negate with a select input. It is used for operand magnitudes and the final sign fix.
- Everything else stays inline.

Test Plan:
- MULTU, op_a=0x00000007, op_b=0x00000006, dest r5 int -> after 33 cycles: wr_en=1, wr_addr=5, wr_data=0x0000002A, ovf=0, done one cycle.
- MULT, op_a=0xFFFFFFFD (-3), op_b=0x00000004 -> wr_data=0xFFFFFFF4, ovf=0. Same operands as MULTU -> wr_data=0xFFFFFFF4, ovf=1.
- MULT, op_a=0x80000000, op_b=0xFFFFFFFF -> wr_data=0x80000000, ovf=1. Then 0x00010000 x 0x00010000 MULTU -> wr_data=0, ovf=1.
- dest r0 int -> done=1, wr_en=0. Same op with dest_ftpt=1 to f0 -> wr_en=1, wr_ftpt=1.
- start pulsed again at cycle 10 of RUN with different operands -> ignored; first result unchanged; busy stays 1 until DONE.
- rst asserted at cycle 15 of RUN -> next cycle IDLE, busy=0, no wr_en/done. Fresh start then completes normally. With MUL_EARLY_TERM_EN, op_b=0x00000001 -> done within 3 cycles of start.
